// File: rtl/mos6502_lite_core.sv
// ============================================================================
// Module   : mos6502_lite_core
// Purpose  : Reduced cycle-accurate 6502 core: reset vector, loads, stores,
//            JMP abs and implied instructions over a registered address bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mos6502_lite_core #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [7:0]  P_RESET      = 8'h34
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rd_data,
    output logic [15:0] address,
    output logic [7:0]  wr_data,
    output logic        wr_enable
);

    localparam logic [2:0] RST_LO   = 3'd0;
    localparam logic [2:0] RST_HI   = 3'd1;
    localparam logic [2:0] RST_JMP  = 3'd2;
    localparam logic [2:0] FETCH    = 3'd3;
    localparam logic [2:0] EXEC2    = 3'd4;
    localparam logic [2:0] ABS_HI   = 3'd5;
    localparam logic [2:0] ABS_EXEC = 3'd6;

    logic [2:0]  r_state;
    logic [15:0] PC;
    logic [7:0]  P;
    logic [7:0]  r_a, r_x, r_y, r_s, r_ir, r_lo, r_hi;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_pc_nxt, w_addr_nxt, w_pc_inc;
    logic [7:0]  w_p_nxt, w_a_nxt, w_x_nxt, w_y_nxt, w_s_nxt;
    logic [7:0]  w_ir_nxt, w_lo_nxt, w_hi_nxt, w_wd_nxt, w_res;
    logic        w_we_nxt, w_set_nz;

    assign w_pc_inc = PC + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = PC;
        w_addr_nxt  = address;
        w_p_nxt     = P;
        w_a_nxt     = r_a;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_s_nxt     = r_s;
        w_ir_nxt    = r_ir;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_wd_nxt    = wr_data;
        w_we_nxt    = 1'b0;
        w_res       = 8'h00;
        w_set_nz    = 1'b0;

        case (r_state)
            RST_LO: begin
                w_lo_nxt    = rd_data;
                w_addr_nxt  = RESET_VECTOR + 16'd1;
                w_state_nxt = RST_HI;
            end
            RST_HI: begin
                w_hi_nxt    = rd_data;
                w_state_nxt = RST_JMP;
            end
            RST_JMP: begin
                w_pc_nxt    = {r_hi, r_lo};
                w_addr_nxt  = {r_hi, r_lo};
                w_state_nxt = FETCH;
            end
            FETCH: begin
                w_ir_nxt    = rd_data;
                w_pc_nxt    = w_pc_inc;
                w_addr_nxt  = w_pc_inc;
                w_state_nxt = EXEC2;
            end
            EXEC2: begin
                case (r_ir)
                    8'hA9, 8'hA2, 8'hA0: begin
                        if (r_ir == 8'hA9) w_a_nxt = rd_data;
                        if (r_ir == 8'hA2) w_x_nxt = rd_data;
                        if (r_ir == 8'hA0) w_y_nxt = rd_data;
                        w_res       = rd_data;
                        w_set_nz    = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_addr_nxt  = w_pc_inc;
                        w_state_nxt = FETCH;
                    end
                    8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C, 8'h4C: begin
                        w_lo_nxt    = rd_data;
                        w_pc_nxt    = w_pc_inc;
                        w_addr_nxt  = w_pc_inc;
                        w_state_nxt = ABS_HI;
                    end
                    default: begin
                        // Implied ops: the cycle is a dummy read of PC
                        w_addr_nxt  = PC;
                        w_state_nxt = FETCH;
                        case (r_ir)
                            8'h18: w_p_nxt[0] = 1'b0;
                            8'h38: w_p_nxt[0] = 1'b1;
                            8'h58: w_p_nxt[2] = 1'b0;
                            8'h78: w_p_nxt[2] = 1'b1;
                            8'hB8: w_p_nxt[6] = 1'b0;
                            8'hAA: begin w_res = r_a;         w_x_nxt = w_res; w_set_nz = 1'b1; end
                            8'h8A: begin w_res = r_x;         w_a_nxt = w_res; w_set_nz = 1'b1; end
                            8'hA8: begin w_res = r_a;         w_y_nxt = w_res; w_set_nz = 1'b1; end
                            8'h98: begin w_res = r_y;         w_a_nxt = w_res; w_set_nz = 1'b1; end
                            8'hE8: begin w_res = r_x + 8'd1;  w_x_nxt = w_res; w_set_nz = 1'b1; end
                            8'hC8: begin w_res = r_y + 8'd1;  w_y_nxt = w_res; w_set_nz = 1'b1; end
                            8'hCA: begin w_res = r_x - 8'd1;  w_x_nxt = w_res; w_set_nz = 1'b1; end
                            8'h88: begin w_res = r_y - 8'd1;  w_y_nxt = w_res; w_set_nz = 1'b1; end
                            default: ;
                        endcase
                    end
                endcase
            end
            ABS_HI: begin
                if (r_ir == 8'h4C) begin
                    w_pc_nxt    = {rd_data, r_lo};
                    w_addr_nxt  = {rd_data, r_lo};
                    w_state_nxt = FETCH;
                end else begin
                    w_pc_nxt    = w_pc_inc;
                    w_addr_nxt  = {rd_data, r_lo};
                    w_state_nxt = ABS_EXEC;
                    // Strobe is registered so it lines up with the effective address
                    case (r_ir)
                        8'h8D: begin w_we_nxt = 1'b1; w_wd_nxt = r_a; end
                        8'h8E: begin w_we_nxt = 1'b1; w_wd_nxt = r_x; end
                        8'h8C: begin w_we_nxt = 1'b1; w_wd_nxt = r_y; end
                        default: ;
                    endcase
                end
            end
            ABS_EXEC: begin
                w_addr_nxt  = PC;
                w_state_nxt = FETCH;
                case (r_ir)
                    8'hAD: begin w_a_nxt = rd_data; w_res = rd_data; w_set_nz = 1'b1; end
                    8'hAE: begin w_x_nxt = rd_data; w_res = rd_data; w_set_nz = 1'b1; end
                    8'hAC: begin w_y_nxt = rd_data; w_res = rd_data; w_set_nz = 1'b1; end
                    default: ;
                endcase
            end
            default: begin
                w_addr_nxt  = RESET_VECTOR;
                w_state_nxt = RST_LO;
            end
        endcase

        if (w_set_nz) begin
            w_p_nxt[7] = w_res[7];
            w_p_nxt[1] = (w_res == 8'h00);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= RST_LO;
            PC        <= 16'h0000;
            P         <= P_RESET;
            r_a       <= 8'h00;
            r_x       <= 8'h00;
            r_y       <= 8'h00;
            r_s       <= 8'hFD;
            r_ir      <= 8'h00;
            r_lo      <= 8'h00;
            r_hi      <= 8'h00;
            address   <= RESET_VECTOR;
            wr_data   <= 8'h00;
            wr_enable <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            PC        <= w_pc_nxt;
            P         <= w_p_nxt;
            r_a       <= w_a_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_s       <= w_s_nxt;
            r_ir      <= w_ir_nxt;
            r_lo      <= w_lo_nxt;
            r_hi      <= w_hi_nxt;
            address   <= w_addr_nxt;
            wr_data   <= w_wd_nxt;
            wr_enable <= w_we_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mos6502_lite_core.sv
// ============================================================================
// Module   : tb_mos6502_lite_core
// Purpose  : Self-checking bench: reset, vector table, reset-abort, random
//            programs against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mos6502_lite_core;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rd_data;
    logic [15:0] address;
    logic [7:0]  wr_data;
    logic        wr_enable;

    logic [7:0]  mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_a, m_x, m_y, m_p;
    logic [15:0] m_pc;

    mos6502_lite_core #(
        .RESET_VECTOR (16'hFFFC),
        .P_RESET      (8'h34)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_data   (rd_data),
        .address   (address),
        .wr_data   (wr_data),
        .wr_enable (wr_enable)
    );

    always #5 clk = ~clk;

    assign rd_data = mem[address];

    always @(posedge clk) begin
        if (wr_enable) mem[address] = wr_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  op, b1, b2, mval;
        int          cyc;
        logic [15:0] epc;
        logic [7:0]  ea, ex, ey, ep;
        logic        we;
        logic [15:0] wa;
        logic [7:0]  wd;
    } vec_t;

    vec_t tbl [33];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Place an instruction at pc and run it for a fixed number of core cycles
    task automatic exec_instr(input logic [15:0] pc, input logic [7:0] op, b1, b2,
                              input int cycles, output int wcnt, output int wcyc,
                              output logic [15:0] wa, output logic [7:0] wd);
        logic [15:0] p1, p2;
        p1 = pc + 16'd1;
        p2 = pc + 16'd2;
        mem[pc] = op;
        mem[p1] = b1;
        mem[p2] = b2;
        wcnt = 0; wcyc = 0; wa = 16'h0; wd = 8'h0;
        for (int c = 1; c <= cycles; c++) begin
            @(posedge clk); #1;
            if (wr_enable) begin
                wcnt++; wcyc = c; wa = address; wd = wr_data;
            end
        end
    endtask

    function automatic logic [7:0] nz(input logic [7:0] p, input logic [7:0] v);
        return {v[7], p[6:2], (v == 8'h00), p[0]};
    endfunction

    // Instruction-level reference: architectural effect and cycle count
    task automatic model_step(input logic [7:0] op, b1, b2, output int cyc,
                              output logic we, output logic [15:0] wa, output logic [7:0] wd);
        logic [15:0] ea;
        ea = {b2, b1};
        we = 1'b0; wa = ea; wd = 8'h00;
        case (op)
            8'hA9: begin m_a = b1; m_p = nz(m_p, b1); m_pc += 16'd2; cyc = 2; end
            8'hA2: begin m_x = b1; m_p = nz(m_p, b1); m_pc += 16'd2; cyc = 2; end
            8'hA0: begin m_y = b1; m_p = nz(m_p, b1); m_pc += 16'd2; cyc = 2; end
            8'hAD: begin m_a = mem[ea]; m_p = nz(m_p, m_a); m_pc += 16'd3; cyc = 4; end
            8'hAE: begin m_x = mem[ea]; m_p = nz(m_p, m_x); m_pc += 16'd3; cyc = 4; end
            8'hAC: begin m_y = mem[ea]; m_p = nz(m_p, m_y); m_pc += 16'd3; cyc = 4; end
            8'h8D: begin we = 1'b1; wd = m_a; m_pc += 16'd3; cyc = 4; end
            8'h8E: begin we = 1'b1; wd = m_x; m_pc += 16'd3; cyc = 4; end
            8'h8C: begin we = 1'b1; wd = m_y; m_pc += 16'd3; cyc = 4; end
            8'h4C: begin m_pc = ea; cyc = 3; end
            default: begin
                cyc = 2;
                m_pc += 16'd1;
                case (op)
                    8'h18: m_p[0] = 1'b0;
                    8'h38: m_p[0] = 1'b1;
                    8'h58: m_p[2] = 1'b0;
                    8'h78: m_p[2] = 1'b1;
                    8'hB8: m_p[6] = 1'b0;
                    8'hAA: begin m_x = m_a; m_p = nz(m_p, m_x); end
                    8'h8A: begin m_a = m_x; m_p = nz(m_p, m_a); end
                    8'hA8: begin m_y = m_a; m_p = nz(m_p, m_y); end
                    8'h98: begin m_a = m_y; m_p = nz(m_p, m_a); end
                    8'hE8: begin m_x = m_x + 8'd1; m_p = nz(m_p, m_x); end
                    8'hC8: begin m_y = m_y + 8'd1; m_p = nz(m_p, m_y); end
                    8'hCA: begin m_x = m_x - 8'd1; m_p = nz(m_p, m_x); end
                    8'h88: begin m_y = m_y - 8'd1; m_p = nz(m_p, m_y); end
                    default: ;
                endcase
            end
        endcase
    endtask

    initial begin
        logic [15:0] cur, wa, ewa;
        logic [7:0]  wd, ewd, op, b1, b2;
        logic        ewe;
        int          wcnt, wcyc, ecyc;
        logic [7:0]  ops [24];

        ops = '{8'hA9, 8'hA2, 8'hA0, 8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C, 8'h4C,
                8'hEA, 8'h18, 8'h38, 8'h58, 8'h78, 8'hB8, 8'hAA, 8'h8A, 8'hA8, 8'h98,
                8'hE8, 8'hC8, 8'hCA, 8'h88};

        //            op     b1     b2     mval   cyc epc       A      X      Y      P     we  wa        wd
        tbl[0]  = '{8'hAD, 8'h00, 8'h90, 8'h80, 4, 16'h8003, 8'h80, 8'h00, 8'h00, 8'hB4, 0, 16'h0000, 8'h00};
        tbl[1]  = '{8'hA9, 8'h00, 8'h00, 8'h00, 2, 16'h8005, 8'h00, 8'h00, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[2]  = '{8'hA2, 8'h05, 8'h00, 8'h00, 2, 16'h8007, 8'h00, 8'h05, 8'h00, 8'h34, 0, 16'h0000, 8'h00};
        tbl[3]  = '{8'h8E, 8'h34, 8'h12, 8'h00, 4, 16'h800A, 8'h00, 8'h05, 8'h00, 8'h34, 1, 16'h1234, 8'h05};
        tbl[4]  = '{8'hA0, 8'hFF, 8'h00, 8'h00, 2, 16'h800C, 8'h00, 8'h05, 8'hFF, 8'hB4, 0, 16'h0000, 8'h00};
        tbl[5]  = '{8'hC8, 8'h00, 8'h00, 8'h00, 2, 16'h800D, 8'h00, 8'h05, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[6]  = '{8'h88, 8'h00, 8'h00, 8'h00, 2, 16'h800E, 8'h00, 8'h05, 8'hFF, 8'hB4, 0, 16'h0000, 8'h00};
        tbl[7]  = '{8'h38, 8'h00, 8'h00, 8'h00, 2, 16'h800F, 8'h00, 8'h05, 8'hFF, 8'hB5, 0, 16'h0000, 8'h00};
        tbl[8]  = '{8'hA8, 8'h00, 8'h00, 8'h00, 2, 16'h8010, 8'h00, 8'h05, 8'h00, 8'h37, 0, 16'h0000, 8'h00};
        tbl[9]  = '{8'hE8, 8'h00, 8'h00, 8'h00, 2, 16'h8011, 8'h00, 8'h06, 8'h00, 8'h35, 0, 16'h0000, 8'h00};
        tbl[10] = '{8'h18, 8'h00, 8'h00, 8'h00, 2, 16'h8012, 8'h00, 8'h06, 8'h00, 8'h34, 0, 16'h0000, 8'h00};
        tbl[11] = '{8'h58, 8'h00, 8'h00, 8'h00, 2, 16'h8013, 8'h00, 8'h06, 8'h00, 8'h30, 0, 16'h0000, 8'h00};
        tbl[12] = '{8'h78, 8'h00, 8'h00, 8'h00, 2, 16'h8014, 8'h00, 8'h06, 8'h00, 8'h34, 0, 16'h0000, 8'h00};
        tbl[13] = '{8'h8A, 8'h00, 8'h00, 8'h00, 2, 16'h8015, 8'h06, 8'h06, 8'h00, 8'h34, 0, 16'h0000, 8'h00};
        tbl[14] = '{8'h02, 8'h00, 8'h00, 8'h00, 2, 16'h8016, 8'h06, 8'h06, 8'h00, 8'h34, 0, 16'h0000, 8'h00};
        tbl[15] = '{8'hCA, 8'h00, 8'h00, 8'h00, 2, 16'h8017, 8'h06, 8'h05, 8'h00, 8'h34, 0, 16'h0000, 8'h00};
        tbl[16] = '{8'hAE, 8'h00, 8'h90, 8'h7F, 4, 16'h801A, 8'h06, 8'h7F, 8'h00, 8'h34, 0, 16'h0000, 8'h00};
        tbl[17] = '{8'hAC, 8'h00, 8'h90, 8'h00, 4, 16'h801D, 8'h06, 8'h7F, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[18] = '{8'h8D, 8'h00, 8'h91, 8'h00, 4, 16'h8020, 8'h06, 8'h7F, 8'h00, 8'h36, 1, 16'h9100, 8'h06};
        tbl[19] = '{8'h8C, 8'h01, 8'h91, 8'h00, 4, 16'h8023, 8'h06, 8'h7F, 8'h00, 8'h36, 1, 16'h9101, 8'h00};
        tbl[20] = '{8'h98, 8'h00, 8'h00, 8'h00, 2, 16'h8024, 8'h00, 8'h7F, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[21] = '{8'hAA, 8'h00, 8'h00, 8'h00, 2, 16'h8025, 8'h00, 8'h00, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[22] = '{8'hB8, 8'h00, 8'h00, 8'h00, 2, 16'h8026, 8'h00, 8'h00, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[23] = '{8'h4C, 8'h00, 8'hA0, 8'h00, 3, 16'hA000, 8'h00, 8'h00, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[24] = '{8'hEA, 8'h00, 8'h00, 8'h00, 2, 16'hA001, 8'h00, 8'h00, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[25] = '{8'h4C, 8'hFF, 8'hFF, 8'h00, 3, 16'hFFFF, 8'h00, 8'h00, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[26] = '{8'hEA, 8'h00, 8'h00, 8'h00, 2, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[27] = '{8'hA9, 8'h80, 8'h00, 8'h00, 2, 16'h0002, 8'h80, 8'h00, 8'h00, 8'hB4, 0, 16'h0000, 8'h00};
        tbl[28] = '{8'hAA, 8'h00, 8'h00, 8'h00, 2, 16'h0003, 8'h80, 8'h80, 8'h00, 8'hB4, 0, 16'h0000, 8'h00};
        tbl[29] = '{8'hCA, 8'h00, 8'h00, 8'h00, 2, 16'h0004, 8'h80, 8'h7F, 8'h00, 8'h34, 0, 16'h0000, 8'h00};
        tbl[30] = '{8'hA2, 8'hFF, 8'h00, 8'h00, 2, 16'h0006, 8'h80, 8'hFF, 8'h00, 8'hB4, 0, 16'h0000, 8'h00};
        tbl[31] = '{8'hE8, 8'h00, 8'h00, 8'h00, 2, 16'h0007, 8'h80, 8'h00, 8'h00, 8'h36, 0, 16'h0000, 8'h00};
        tbl[32] = '{8'h88, 8'h00, 8'h00, 8'h00, 2, 16'h0008, 8'h80, 8'h00, 8'hFF, 8'hB4, 0, 16'h0000, 8'h00};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        mem[16'h9101] = 8'h5A;

        // Reset state and vector sequence
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_P", dut.P, 8'h34);
        chk("rst_PC", dut.PC, 16'h0000);
        chk("rst_addr", address, 16'hFFFC);
        chk("rst_we", wr_enable, 1'b0);
        chk("rst_wd", wr_data, 8'h00);
        chk("rst_A", dut.r_a, 8'h00);
        chk("rst_X", dut.r_x, 8'h00);
        chk("rst_Y", dut.r_y, 8'h00);
        chk("rst_S", dut.r_s, 8'hFD);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("vec_e1_addr", address, 16'hFFFD);
        chk("vec_e1_PC", dut.PC, 16'h0000);
        @(posedge clk); #1;
        chk("vec_e2_PC", dut.PC, 16'h0000);
        @(posedge clk); #1;
        chk("vec_e3_PC", dut.PC, 16'h8000);
        chk("vec_e3_addr", address, 16'h8000);

        // Directed vector table
        cur = 16'h8000;
        for (int i = 0; i < 33; i++) begin
            mem[16'h9000] = tbl[i].mval;
            exec_instr(cur, tbl[i].op, tbl[i].b1, tbl[i].b2, tbl[i].cyc, wcnt, wcyc, wa, wd);
            chk($sformatf("t%0d_PC", i), dut.PC, tbl[i].epc);
            chk($sformatf("t%0d_addr", i), address, tbl[i].epc);
            chk($sformatf("t%0d_A", i), dut.r_a, tbl[i].ea);
            chk($sformatf("t%0d_X", i), dut.r_x, tbl[i].ex);
            chk($sformatf("t%0d_Y", i), dut.r_y, tbl[i].ey);
            chk($sformatf("t%0d_P", i), dut.P, tbl[i].ep);
            chk($sformatf("t%0d_wcnt", i), wcnt, tbl[i].we ? 1 : 0);
            if (tbl[i].we) begin
                chk($sformatf("t%0d_wcyc", i), wcyc, tbl[i].cyc - 1);
                chk($sformatf("t%0d_waddr", i), wa, tbl[i].wa);
                chk($sformatf("t%0d_wdata", i), wd, tbl[i].wd);
                chk($sformatf("t%0d_mem", i), mem[tbl[i].wa], tbl[i].wd);
            end
            cur = tbl[i].epc;
        end

        // Reset during cycle 3 of STA $6655 must suppress the write
        mem[16'h6655] = 8'h11;
        mem[cur] = 8'h8D;
        mem[cur + 16'd1] = 8'h55;
        mem[cur + 16'd2] = 8'h66;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("abort_we", wr_enable, 1'b0);
        chk("abort_addr", address, 16'hFFFC);
        chk("abort_P", dut.P, 8'h34);
        wcnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (wr_enable) wcnt++;
        end
        chk("abort_wcnt", wcnt, 0);
        chk("abort_mem", mem[16'h6655], 8'h11);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_vec_PC", dut.PC, 16'h8000);
        chk("abort_vec_addr", address, 16'h8000);

        // Randomized programs against the reference model
        m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_p = 8'h34; m_pc = 16'h8000;
        for (int i = 0; i < 256; i++) mem[16'h3000 + i] = 8'($urandom);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 29) < 24) op = ops[$urandom_range(0, 23)];
            else op = 8'($urandom);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            case (op)
                8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C: b2 = 8'h30;
                8'h4C: b2 = 8'($urandom_range(8'h04, 8'h20));
                default: ;
            endcase
            cur = m_pc;
            model_step(op, b1, b2, ecyc, ewe, ewa, ewd);
            exec_instr(cur, op, b1, b2, ecyc, wcnt, wcyc, wa, wd);
            chk($sformatf("r%0d_op%0h_PC", n, op), dut.PC, m_pc);
            chk($sformatf("r%0d_op%0h_addr", n, op), address, m_pc);
            chk($sformatf("r%0d_op%0h_A", n, op), dut.r_a, m_a);
            chk($sformatf("r%0d_op%0h_X", n, op), dut.r_x, m_x);
            chk($sformatf("r%0d_op%0h_Y", n, op), dut.r_y, m_y);
            chk($sformatf("r%0d_op%0h_P", n, op), dut.P, m_p);
            chk($sformatf("r%0d_op%0h_wcnt", n, op), wcnt, ewe ? 1 : 0);
            if (ewe) begin
                chk($sformatf("r%0d_waddr", n), wa, ewa);
                chk($sformatf("r%0d_wdata", n), wd, ewd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mos6502_lite_core.md
Name: mos6502_lite_core

Overview:
- Reduced, cycle-accurate MOS 6502-compatible processor core for the system-level bench.
- Drives a single 16-bit address bus to a synchronous RAM/ROM. The memory runs on a clock 10x faster than the core, so the read data for the current cycle's address is valid before the next core clock edge.
- Implements the 6502 reset-vector sequence and a small load/store/jump instruction subset with native 6502 cycle counts.

Parameters:
- RESET_VECTOR, 16'hFFFC, address of the low byte of the reset vector; the high byte is at RESET_VECTOR+1.
- P_RESET, 8'h34, processor status value loaded on reset: I=1, bit5=1, B=1.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rd_data  in  8  memory read data for the address driven in the current cycle.
- address  out  16  memory address; registered.
- wr_data  out  8  memory write data.
- wr_enable  out  1  memory write strobe; one cycle per store.

Behaviour:
- Internal registers A, X, Y (8-bit), PC (16-bit), P (8-bit), S (8-bit), IR (8-bit), plus a state register.
- Registers PC and P keep exactly those names so benches can probe them hierarchically.
- P bit layout: 0=C, 1=Z, 2=I, 3=D, 4=B, 5=1, 6=V, 7=N.
- Reset asserted:
  - A=X=Y=0, S=8'hFD, P=P_RESET, PC=16'h0000.
  - address=RESET_VECTOR, wr_enable=0, wr_data=0, state=RST_LO.
- Reset sequence, counted in rising edges after resetn deasserts:
  - Edge 1: capture the vector low byte from rd_data; drive address=RESET_VECTOR+1.
  - Edge 2: capture the high byte.
  - Edge 3: PC <= {hi, lo}; address <= the same value; state=FETCH.
  - PC therefore equals the vector contents after the 3rd edge.
- Fetch: on the edge in FETCH, IR <= rd_data, PC <= PC+1, address <= PC+1. Cycle counts below include this fetch cycle.
- Immediate loads (2 cycles): LDA #A9, LDX #A2, LDY #A0.
  - Cycle 2 loads the register from rd_data and sets PC+1.
  - N and Z are updated from the loaded value.
- Absolute loads (4 cycles): LDA AD, LDX AE, LDY AC.
  - Cycle 2: latch the operand low byte; PC+1.
  - Cycle 3: latch the high byte; PC+1; address <= effective address.
  - Cycle 4: load the register from rd_data; update N/Z; address <= PC. No PC change in this cycle.
- Absolute stores (4 cycles): STA 8D, STX 8E, STY 8C.
  - Same operand cycles as absolute loads.
  - Cycle 4 drives address=effective, wr_data=register, wr_enable=1 for exactly that cycle. Flags are unchanged.
- JMP abs 4C (3 cycles): cycle 3 sets PC <= {rd_data, lo} and address to the same value.
- Implied instructions (2 cycles, dummy read of PC): NOP EA, CLC 18, SEC 38, CLI 58, SEI 78, CLV B8, TAX AA, TXA 8A, TAY A8, TYA 98, INX E8, INY C8, DEX CA, DEY 88.
  - Transfers and increments/decrements update N/Z.
  - INX/INY/DEX/DEY wrap modulo 256 (FF+1=00, 00-1=FF).
- Any other opcode executes as a 2-cycle NOP.
- PC increments wrap from FFFF to 0000.
- Z = (result==0). N = result[7]. C, V and D change only via the explicit flag instructions.
- wr_enable is 0 in every cycle except a store write cycle.
- Reset asserted mid-instruction aborts it immediately, with no write issued after the reset edge, and restarts the vector sequence.

Test Plan:
- Vector FFFC=00, FFFD=80; release reset -> PC==16'h8000 after the 3rd rising edge; P==8'h34 during reset.
- Program at 8000: AD 00 90 with mem[9000]=80 -> PC==8003 exactly 4 edges after PC==8000; A==80; N=1; Z=0.
- A9 00 -> A==00, Z=1, N=0 after 2 cycles; PC advances by 2.
- A2 05, 8E 34 12 -> wr_enable high for exactly one cycle with address=1234, wr_data=05; mem[1234]==05 afterwards.
- 4C 00 A0 -> PC==A000 after 3 cycles; next fetch from A000.
- Pull resetn low during cycle 3 of a store -> no write occurs; vector sequence restarts; PC==vector after 3 edges.
